io_channel_bank: RTL and testbench
==================================

# io_channel_bank

Parametrised memory-mapped I/O subsystem for the multicycle processor. It replaces the single fixed 16-bit io_in/io_out pair with NUM_CH independent channels. Each channel has a buffered receive FIFO, a handshaked transmit register and a sticky-error status word. The block sits on the processor's memory-access path and is selected when the memory-destination decode targets I/O. The processor reads and writes it through a small register window.

## Interface
- WIDTH, 16, data width of every channel and of the CPU data bus
- NUM_CH, 4, number of channels (1..16)
- DEPTH, 4, receive FIFO entries per channel (power of two, ≥2)
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_addr  in  $clog2(NUM_CH)+1  {channel, sel}; sel=0 data register, sel=1 status register
- cpu_rd  in  1  read strobe, one cycle
- cpu_wr  in  1  write strobe, one cycle; if both strobes are high, the write wins and the read is ignored
- cpu_wdata  in  WIDTH  write data
- cpu_rdata  out  WIDTH  registered read data
- in_data  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_valid  in  NUM_CH  external producer has a word
- in_ready  out  NUM_CH  receive FIFO not full
- out_data  out  NUM_CH*WIDTH  transmit register contents
- out_valid  out  NUM_CH  transmit register holds a word
- out_ready  in  NUM_CH  external consumer accepts the word
- irq  out  1  OR over channels of (rx count ≠ 0)

## Operation
- Receive path, per channel:
  - A push occurs when in_valid[c] && in_ready[c].
  - in_ready[c] = (count < DEPTH), driven combinationally from registered count.
- Data read (sel=0) of channel c:
  - If the FIFO is non-empty: pop the head; cpu_rdata = head word.
  - If empty: cpu_rdata = 0; set sticky rx_underflow[c].
- Same-edge push and pop on the same channel:
  - Count is unchanged.
  - When the FIFO is empty, the pop underflows and the push still lands; count becomes 1.
- Data write (sel=0) of channel c:
  - If !out_valid[c], or out_valid[c] && out_ready[c] in the same cycle: load out_data[c], set out_valid[c].
  - Otherwise: drop the word, set sticky tx_drop[c], leave out_data unchanged.
- Transmit handshake:
  - out_valid && out_ready with no CPU write clears out_valid.
  - out_data holds its value until the handshake completes.
- Status read (sel=1), bits:
  - [0] rx_nonempty
  - [1] out_valid
  - [2] rx_underflow
  - [3] tx_drop
  - [4 +: $clog2(DEPTH+1)] rx count
  - remaining bits 0
  - Reading status has no side effects.
- Status write (sel=1): write-1-to-clear. wdata[2] clears rx_underflow, wdata[3] clears tx_drop. Other bits are ignored.
- A sticky bit set and cleared on the same edge ends up set (set wins).
- cpu_addr channel field ≥ NUM_CH: reads return 0, writes have no effect, and no sticky bit changes.
- FIFO pointers wrap modulo DEPTH. Count is kept separately, so full and empty are unambiguous.

## Timing
- Read latency is 1 cycle: cpu_rdata is valid the cycle after the cpu_rd edge and holds until the next read.
- The pop takes effect at the same edge as the read capture.
- A pushed word is visible in status and readable on the next cycle; no bypass from in_data to cpu_rdata.
- in_ready reflects registered count only; a pop in cycle N raises in_ready in cycle N+1.
- The transmit register is loaded at the write edge; out_valid is high from the next cycle.
- Reset values:
  - cpu_rdata = 0, out_data = 0, out_valid = 0
  - all counts and pointers = 0, so in_ready = all 1s and irq = 0
  - sticky bits = 0
- Reset asserted mid-transfer discards FIFO contents and pending transmit words. There is no handshake completion during reset.

## Structure
- Shared package io_bank_pkg holds:
  - SEL_DATA / SEL_STATUS constants
  - status bit indices (ST_RX_NONEMPTY, ST_TX_VALID, ST_RX_UNDERFLOW, ST_TX_DROP, ST_COUNT_LSB)
- Sub-module io_rx_fifo (WIDTH, DEPTH):
  - ports: clock, reset, push, push_data, pop, head, count, full, empty
  - instantiated once per channel through a generate loop
- Transmit register, sticky bits and the address decode live in the top level, each built per channel.

## Test plan
- Reset, then read status ch0 → 0x0000; in_ready = 4'b1111, out_valid = 0, irq = 0.
- Push 0x1111, 0x2222, 0x3333, 0x4444 on ch1:
  - in_ready[1] drops after the 4th push; a 5th in_valid is held off.
  - Status ch1 = 0x0041.
  - Four data reads return 0x1111..0x4444 in order, each one cycle after cpu_rd.
- Read ch2 data while empty → cpu_rdata = 0, status = 0x0004; write status 0x0004 → status 0x0000.
- ch0, out_ready held 0:
  - Write 0xABCD → out_valid[0] = 1, out_data = 0xABCD.
  - Write 0x1234 → word dropped, status bit3 set, out_data still 0xABCD.
  - Raise out_ready for 1 cycle → out_valid[0] = 0.
- Same-cycle push and pop:
  - FIFO holding 1 word → count stays 1, the old word is read out and the new word is retained.
  - Empty FIFO → underflow flag set, count becomes 1.
- Assert reset while ch3 holds 3 words and out_valid[3] = 1 → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_bank_pkg.sv
// Shared constants for the I/O channel bank: register-window select codes
// and bit positions inside the per-channel status word.
package io_bank_pkg;

  localparam logic SEL_DATA   = 1'b0;
  localparam logic SEL_STATUS = 1'b1;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_VALID     = 1;
  localparam int ST_RX_UNDERFLOW = 2;
  localparam int ST_TX_DROP      = 3;
  localparam int ST_COUNT_LSB    = 4;

endpackage

// File: rtl/io_rx_fifo.sv
// Per-channel receive FIFO: wrapping pointers plus a separate occupancy count,
// so full and empty are unambiguous. Head is presented combinationally.
module io_rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Guard against overflow/underflow even if the caller does not.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/io_channel_bank.sv
// Memory-mapped bank of NUM_CH I/O channels: receive FIFO, handshaked transmit
// register and sticky error bits per channel, behind a {channel, sel} window.
module io_channel_bank
  import io_bank_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(NUM_CH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AW-1:0]           cpu_addr,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [WIDTH-1:0]        cpu_wdata,
  output logic [WIDTH-1:0]        cpu_rdata,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic                    irq
);

  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNTW = $clog2(DEPTH+1);

  logic             sel;
  logic [CHW-1:0]   ch_field;
  logic             ch_ok;
  logic             rd_eff;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] empty;
  logic [WIDTH-1:0] rd_word [NUM_CH];
  logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;

  generate
    if (NUM_CH > 1) begin : g_ch_field
      assign ch_field = cpu_addr[AW-1:1];
    end else begin : g_ch_zero
      assign ch_field = '0;
    end
  endgenerate

  assign sel    = cpu_addr[0];
  assign ch_ok  = (32'(ch_field) < NUM_CH);
  // A simultaneous write suppresses the read entirely, including its pop.
  assign rd_eff = cpu_rd && !cpu_wr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             rd_data, wr_data, wr_stat;
      logic             push, pop, full, load;
      logic [WIDTH-1:0] head;
      logic [CNTW-1:0]  count;
      logic             ov_q, ov_d, uf_q, uf_d, drop_q, drop_d;
      logic [WIDTH-1:0] od_q, od_d;
      logic [WIDTH-1:0] status;

      assign hit[gi]  = ch_ok && (ch_field == CHW'(gi));
      assign rd_data  = rd_eff && hit[gi] && (sel == SEL_DATA);
      assign wr_data  = cpu_wr && hit[gi] && (sel == SEL_DATA);
      assign wr_stat  = cpu_wr && hit[gi] && (sel == SEL_STATUS);
      assign push     = in_valid[gi] && !full;
      assign pop      = rd_data && !empty[gi];

      io_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_data[gi*WIDTH +: WIDTH]),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty[gi])
      );

      // The slot is free if empty or being drained by the consumer this cycle.
      assign load   = wr_data && (!ov_q || out_ready[gi]);
      assign ov_d   = load || (ov_q && !out_ready[gi]);
      assign od_d   = load ? cpu_wdata : od_q;
      assign uf_d   = (rd_data && empty[gi]) ||
                      (uf_q && !(wr_stat && cpu_wdata[ST_RX_UNDERFLOW]));
      assign drop_d = (wr_data && ov_q && !out_ready[gi]) ||
                      (drop_q && !(wr_stat && cpu_wdata[ST_TX_DROP]));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ov_q   <= 1'b0;
          od_q   <= '0;
          uf_q   <= 1'b0;
          drop_q <= 1'b0;
        end else begin
          ov_q   <= ov_d;
          od_q   <= od_d;
          uf_q   <= uf_d;
          drop_q <= drop_d;
        end
      end

      always_comb begin
        status                            = '0;
        status[ST_RX_NONEMPTY]            = !empty[gi];
        status[ST_TX_VALID]               = ov_q;
        status[ST_RX_UNDERFLOW]           = uf_q;
        status[ST_TX_DROP]                = drop_q;
        status[ST_COUNT_LSB +: CNTW]      = count;
      end

      assign rd_word[gi] = (sel == SEL_STATUS) ? status :
                           (empty[gi] ? '0 : head);

      assign in_ready[gi]                 = !full;
      assign out_valid[gi]                = ov_q;
      assign out_data[gi*WIDTH +: WIDTH]  = od_q;
    end
  endgenerate

  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    if (rd_eff) begin
      cpu_rdata_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hit[c]) cpu_rdata_d = rd_word[c];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cpu_rdata_q <= '0;
    else       cpu_rdata_q <= cpu_rdata_d;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign irq       = |(~empty);

endmodule

// File: tb/tb_io_channel_bank.sv
// Bench for io_channel_bank: hand-derived vector table, hand sequences for
// same-edge push/pop and asynchronous reset, then randomized model checking.
module tb_io_channel_bank;

  localparam int W = 16;
  localparam int N = 4;
  localparam int D = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [2:0]     cpu_addr;
  logic           cpu_rd, cpu_wr;
  logic [W-1:0]   cpu_wdata, cpu_rdata;
  logic [N*W-1:0] in_data, out_data;
  logic [N-1:0]   in_valid, in_ready, out_valid, out_ready;
  logic           irq;

  int tests = 0;
  int fails = 0;

  io_channel_bank #(.WIDTH(W), .NUM_CH(N), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  // Reference model: one queue per channel plus transmit/sticky state.
  logic [W-1:0] mq [N][$];
  logic [N-1:0] m_ov, m_uf, m_drop;
  logic [W-1:0] m_od [N];
  logic [W-1:0] m_rdata;

  function automatic logic [W-1:0] m_status(int c);
    logic [W-1:0] s = '0;
    s[0]   = (mq[c].size() != 0);
    s[1]   = m_ov[c];
    s[2]   = m_uf[c];
    s[3]   = m_drop[c];
    s[6:4] = 3'(mq[c].size());
    return s;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      m_od[c] = '0;
    end
    m_ov = '0; m_uf = '0; m_drop = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    int           ch;
    logic [N-1:0] pushes, load;
    ch   = int'(cpu_addr[2:1]);
    load = '0;
    for (int c = 0; c < N; c++) pushes[c] = in_valid[c] && (mq[c].size() < D);
    if (cpu_wr) begin
      if (!cpu_addr[0]) begin
        if (!m_ov[ch] || out_ready[ch]) begin
          m_od[ch] = cpu_wdata;
          load[ch] = 1'b1;
        end else begin
          m_drop[ch] = 1'b1;
        end
      end else begin
        if (cpu_wdata[2]) m_uf[ch] = 1'b0;
        if (cpu_wdata[3]) m_drop[ch] = 1'b0;
      end
    end else if (cpu_rd) begin
      if (!cpu_addr[0]) begin
        if (mq[ch].size() > 0) m_rdata = mq[ch].pop_front();
        else begin
          m_rdata = '0;
          m_uf[ch] = 1'b1;
        end
      end else begin
        m_rdata = m_status(ch);
      end
    end
    for (int c = 0; c < N; c++) begin
      if (load[c]) m_ov[c] = 1'b1;
      else if (m_ov[c] && out_ready[c]) m_ov[c] = 1'b0;
      if (pushes[c]) mq[c].push_back(in_data[c*W +: W]);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [2:0] a,
                     input logic [W-1:0] wd, input logic [N-1:0] iv,
                     input logic [N*W-1:0] idat, input logic [N-1:0] ordy);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    in_valid = iv; in_data = idat; out_ready = ordy;
    model_step();
    @(posedge clock);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; in_valid = '0; out_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic         rd, wr;
    logic [2:0]   addr;
    logic [W-1:0] wdata;
    logic [N-1:0] iv;
    logic [W-1:0] iw;
    logic [N-1:0] ordy;
    logic [W-1:0] e_rdata;
    logic [N-1:0] e_irdy;
    logic [N-1:0] e_ov;
    logic [W-1:0] e_od0;
    logic         e_irq;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] a, logic [W-1:0] wd,
                              logic [N-1:0] iv, logic [W-1:0] iw, logic [N-1:0] ordy,
                              logic [W-1:0] er, logic [N-1:0] eir, logic [N-1:0] eov,
                              logic [W-1:0] eod, logic eirq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.iv = iv; v.iw = iw;
    v.ordy = ordy; v.e_rdata = er; v.e_irdy = eir; v.e_ov = eov;
    v.e_od0 = eod; v.e_irq = eirq;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    reset = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    in_valid = '0; in_data = '0; out_ready = '0;
    m_reset();

    //            rd wr addr   wdata    iv      iw       ordy    rdata    irdy    ov      od0      irq
    tbl[0]  = mk(1, 0, 3'b001, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0);
    tbl[1]  = mk(0, 0, 3'b000, 16'h0, 4'b0010, 16'h1111, 4'b0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 1);
    tbl[2]  = mk(0, 0, 3'b000, 16'h0, 4'b0010, 16'h2222, 4'b0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 1);
    tbl[3]  = mk(0, 0, 3'b000, 16'h0, 4'b0010, 16'h3333, 4'b0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 1);
    tbl[4]  = mk(0, 0, 3'b000, 16'h0, 4'b0010, 16'h4444, 4'b0000, 16'h0000, 4'hD, 4'h0, 16'h0000, 1);
    tbl[5]  = mk(0, 0, 3'b000, 16'h0, 4'b0010, 16'h5555, 4'b0000, 16'h0000, 4'hD, 4'h0, 16'h0000, 1);
    tbl[6]  = mk(1, 0, 3'b011, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h0041, 4'hD, 4'h0, 16'h0000, 1);
    tbl[7]  = mk(1, 0, 3'b010, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h1111, 4'hF, 4'h0, 16'h0000, 1);
    tbl[8]  = mk(1, 0, 3'b010, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h2222, 4'hF, 4'h0, 16'h0000, 1);
    tbl[9]  = mk(1, 0, 3'b010, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h3333, 4'hF, 4'h0, 16'h0000, 1);
    tbl[10] = mk(1, 0, 3'b010, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h4444, 4'hF, 4'h0, 16'h0000, 0);
    tbl[11] = mk(1, 0, 3'b100, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0);
    tbl[12] = mk(1, 0, 3'b101, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h0004, 4'hF, 4'h0, 16'h0000, 0);
    tbl[13] = mk(0, 1, 3'b101, 16'h4, 4'b0000, 16'h0,    4'b0000, 16'h0004, 4'hF, 4'h0, 16'h0000, 0);
    tbl[14] = mk(1, 0, 3'b101, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0);
    tbl[15] = mk(0, 1, 3'b000, 16'hABCD, 4'b0000, 16'h0, 4'b0000, 16'h0000, 4'hF, 4'h1, 16'hABCD, 0);
    tbl[16] = mk(0, 1, 3'b000, 16'h1234, 4'b0000, 16'h0, 4'b0000, 16'h0000, 4'hF, 4'h1, 16'hABCD, 0);
    tbl[17] = mk(1, 0, 3'b001, 16'h0, 4'b0000, 16'h0,    4'b0000, 16'h000A, 4'hF, 4'h1, 16'hABCD, 0);
    tbl[18] = mk(0, 0, 3'b000, 16'h0, 4'b0000, 16'h0,    4'b0001, 16'h000A, 4'hF, 4'h0, 16'hABCD, 0);

    @(posedge clock);
    #1;
    check("reset_rdata", cpu_rdata, 16'h0);
    check("reset_in_ready", in_ready, 4'hF);
    check("reset_out_valid", out_valid, 4'h0);
    check("reset_irq", irq, 1'b0);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].iv,
          {N{tbl[i].iw}}, tbl[i].ordy);
      $display("[TB] vec %0d rd=%0b wr=%0b addr=%0d rdata=%h in_ready=%b out_valid=%b",
               i, tbl[i].rd, tbl[i].wr, tbl[i].addr, cpu_rdata, in_ready, out_valid);
      check($sformatf("vec%0d_rdata", i), cpu_rdata, tbl[i].e_rdata);
      check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_irdy);
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("vec%0d_out_data0", i), out_data[15:0], tbl[i].e_od0);
      check($sformatf("vec%0d_irq", i), irq, tbl[i].e_irq);
    end

    // Same-edge push and pop on ch0, first with one word held, then empty.
    cyc(0, 1, 3'b001, 16'h0008, 4'b0000, '0, 4'b0000);
    cyc(0, 0, 3'b000, 16'h0, 4'b0001, {N{16'hAAAA}}, 4'b0000);
    cyc(1, 0, 3'b000, 16'h0, 4'b0001, {N{16'hBBBB}}, 4'b0000);
    $display("[TB] push+pop one held: rdata=%h", cpu_rdata);
    check("pp_held_rdata", cpu_rdata, 16'hAAAA);
    cyc(1, 0, 3'b001, 16'h0, 4'b0000, '0, 4'b0000);
    check("pp_held_status", cpu_rdata, 16'h0011);
    cyc(1, 0, 3'b000, 16'h0, 4'b0000, '0, 4'b0000);
    check("pp_held_new_word", cpu_rdata, 16'hBBBB);
    cyc(1, 0, 3'b000, 16'h0, 4'b0001, {N{16'hCCCC}}, 4'b0000);
    $display("[TB] push+pop empty: rdata=%h", cpu_rdata);
    check("pp_empty_rdata", cpu_rdata, 16'h0000);
    cyc(1, 0, 3'b001, 16'h0, 4'b0000, '0, 4'b0000);
    check("pp_empty_status", cpu_rdata, 16'h0015);
    cyc(1, 0, 3'b000, 16'h0, 4'b0000, '0, 4'b0000);
    check("pp_empty_word", cpu_rdata, 16'hCCCC);

    // Asynchronous reset with ch3 holding three words and a pending transmit.
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 3'b000, 16'h0, 4'b1000, {N{16'(16'h3A00 + k)}}, 4'b0000);
    cyc(0, 1, 3'b110, 16'h7777, 4'b0000, '0, 4'b0000);
    cyc(1, 0, 3'b111, 16'h0, 4'b0000, '0, 4'b0000);
    check("pre_reset_status3", cpu_rdata, 16'h0033);
    check("pre_reset_out_valid", out_valid, 4'h8);
    #2;
    reset = 1'b1;
    #1;
    $display("[TB] async reset: rdata=%h out_valid=%b in_ready=%b irq=%b",
             cpu_rdata, out_valid, in_ready, irq);
    check("areset_rdata", cpu_rdata, 16'h0);
    check("areset_out_valid", out_valid, 4'h0);
    check("areset_out_data", out_data, 64'h0);
    check("areset_in_ready", in_ready, 4'hF);
    check("areset_irq", irq, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic         rd, wr;
      logic [N-1:0] exp_ready;
      logic [N*W-1:0] exp_od;
      rd = ($urandom_range(0, 99) < 35);
      wr = ($urandom_range(0, 99) < 20);
      cyc(rd, wr, 3'($urandom_range(0, 7)), 16'($urandom),
          4'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15) & 4'($urandom)));
      for (int c = 0; c < N; c++) begin
        exp_ready[c] = (mq[c].size() < D);
        exp_od[c*W +: W] = m_od[c];
      end
      check($sformatf("rnd%0d_rdata", i), cpu_rdata, m_rdata);
      check($sformatf("rnd%0d_out_valid", i), out_valid, m_ov);
      check($sformatf("rnd%0d_out_data", i), out_data, exp_od);
      check($sformatf("rnd%0d_in_ready", i), in_ready, exp_ready);
      check($sformatf("rnd%0d_irq", i), irq, (exp_ready != 4'hF) || mq[0].size() != 0 ||
            mq[1].size() != 0 || mq[2].size() != 0 || mq[3].size() != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
